fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + hazard controller for the in-order RV32 pipeline.
//  Tracks in-flight destination registers in a DEPTH-entry shadow shift register (entry0 = EX).
//  Selects bypass sources for ID operands, generates load-use stall, inserts bubbles and honours flush.
//  Counts stall cycles. Sits between ID and the ID/EX pipeline register; replaces the fixed 3-stage detect logic.
// PARAMETERS
//  XLEN      32  datapath width
//  REG_BITS  5   register index width
//  DEPTH     3   in-flight stages tracked after ID (EX, MEM, WB); DEPTH >= 2
//  LOAD_LAT  1   load data is forwardable only from entry index >= LOAD_LAT
//  SELW      $clog2(DEPTH+1)  forward-select width (derived, do not override)
// PORTS
//  clk           in   1             rising-edge clock
//  rst           in   1             asynchronous, active-low reset
//  id_valid      in   1             ID holds a valid instruction
//  id_rs1        in   REG_BITS      source 1 index
//  id_rs2        in   REG_BITS      source 2 index
//  id_rs1_used   in   1             instruction reads rs1
//  id_rs2_used   in   1             instruction reads rs2
//  id_rd         in   REG_BITS      destination index
//  id_rf_wen     in   1             instruction writes rd
//  id_is_load    in   1             instruction is a load
//  flush         in   1             kill ID instruction (taken branch/jump)
//  rf_rdata1     in   XLEN          register-file read, source 1
//  rf_rdata2     in   XLEN          register-file read, source 2
//  stage_data    in   DEPTH*XLEN    result of entry k at bits [k*XLEN +: XLEN]
//  fwd_rs1_data  out  XLEN          resolved operand 1
//  fwd_rs2_data  out  XLEN          resolved operand 2
//  fwd_sel1      out  SELW          0 = RF, k+1 = entry k
//  fwd_sel2      out  SELW          as fwd_sel1
//  stall         out  1             hold PC and IF/ID, inject bubble into EX
//  occ           out  DEPTH         valid-write mask of entries (debug)
//  stall_cnt     out  32            stall cycles since reset
// BEHAVIOUR
//  - Entry = {vld, rd, is_load}; vld only when rf_wen=1 and rd!=0 (x0 never tracked/matched).
//  - Reset (rst=0, async): all entries vld=0, stall_cnt=0; thus stall=0, fwd_sel*=0, occ=0.
//  - Every clock: entry[k] <= entry[k-1] for k=1..DEPTH-1 (downstream never stalls); oldest drops out.
//  - entry[0] <= bubble if flush | stall | !id_valid; else {id_rf_wen & id_rd!=0, id_rd, id_is_load}.
//  - Match k (per source): used & vld[k] & rd[k]==rs. Youngest (lowest k) match wins.
//  - fwd_sel = winning k+1 else 0; fwd_data = stage_data[k] or rf_rdata. Combinational, 0 latency.
//  - Load-use: if winning match has is_load & k < LOAD_LAT -> hazard. Older matches are not consulted.
//  - stall = id_valid & !flush & (hazard1 | hazard2). Combinational from entries and ID inputs.
//  - Stall persists until the load entry reaches index LOAD_LAT (LOAD_LAT - k cycles).
//  - flush & hazard same cycle: flush wins, stall=0, bubble into entry0.
//  - stall_cnt increments on every cycle with stall=1; wraps 0xFFFFFFFF -> 0.
//  - Reset mid-stall: entries cleared immediately; stall drops asynchronously with reset.
//  - Write in last entry is assumed committed to RF at that edge; a read of the same rd the
//    next cycle returns RF data (no RF write-through dependence beyond DEPTH).
// STRUCTURE
//  - Shared package cpu_pkg: XLEN, REG_BITS, entry struct/field offsets, SELW function.
//  - One sub-module fwd_src_sel (match priority + hazard flag + data mux), instantiated twice.
//  - Top holds the entry shift register, stall logic and stall_cnt.
// TESTING
//  - Reset: rst=0 with random inputs -> stall=0, occ=0, stall_cnt=0, fwd_sel1=fwd_sel2=0.
//  - ALU chain: issue addi x5 (rd=5), next ID rs1=5 -> fwd_sel1=1, fwd_rs1_data=stage_data[0]; a cycle later -> 2.
//  - Youngest wins: x7 in entry1 and entry0 -> fwd_sel2=1, data from entry0 not entry1.
//  - Load-use: lw x3 issued, next ID rs2=3 -> stall=1 one cycle, occ[0]=0 next, then fwd_sel2=2; stall_cnt=1.
//  - x0/unused: rd=0 writer, rs1=0 or id_rs1_used=0 -> fwd_sel1=0, no stall.
//  - Flush+hazard: load in entry0, ID uses it, flush=1 -> stall=0, entry0 bubble, stall_cnt unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline constants and helpers for the forwarding/hazard slice.
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_BITS = 5;

    // Layout of one in-flight shadow entry at the default register width.
    typedef struct packed {
        logic                vld;
        logic [REG_BITS-1:0] rd;
        logic                is_load;
    } entry_t;

    // Forward-select width: 0 = register file, k+1 = entry k.
    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side operand/hazard bundle between the decode stage and fwd_hazard_unit.
interface fwd_hazard_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN     = cpu_pkg::XLEN,
    parameter int unsigned REG_BITS = cpu_pkg::REG_BITS,
    parameter int unsigned DEPTH    = 3
);
    localparam int unsigned SELW = sel_w(DEPTH);

    logic                  id_valid;
    logic [REG_BITS-1:0]   id_rs1;
    logic [REG_BITS-1:0]   id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_BITS-1:0]   id_rd;
    logic                  id_rf_wen;
    logic                  id_is_load;
    logic                  flush;
    logic [XLEN-1:0]       rf_rdata1;
    logic [XLEN-1:0]       rf_rdata2;
    logic [DEPTH*XLEN-1:0] stage_data;

    logic [XLEN-1:0]       fwd_rs1_data;
    logic [XLEN-1:0]       fwd_rs2_data;
    logic [SELW-1:0]       fwd_sel1;
    logic [SELW-1:0]       fwd_sel2;
    logic                  stall;
    logic [DEPTH-1:0]      occ;
    logic [31:0]           stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rf_wen, id_is_load, flush, rf_rdata1, rf_rdata2, stage_data,
        input  fwd_rs1_data, fwd_rs2_data, fwd_sel1, fwd_sel2, stall, occ, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rf_wen, id_is_load, flush, rf_rdata1, rf_rdata2, stage_data,
        output fwd_rs1_data, fwd_rs2_data, fwd_sel1, fwd_sel2, stall, occ, stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_unit_src_sel.sv
// Per-operand bypass selection: youngest matching in-flight writer wins.
module fwd_src_sel
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN     = cpu_pkg::XLEN,
    parameter int unsigned REG_BITS = cpu_pkg::REG_BITS,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SELW     = sel_w(DEPTH)
) (
    input  logic                      used,
    input  logic [REG_BITS-1:0]       rs,
    input  logic [DEPTH-1:0]          vld,
    input  logic [DEPTH*REG_BITS-1:0] rd,
    input  logic [DEPTH-1:0]          is_load,
    input  logic [DEPTH*XLEN-1:0]     stage_data,
    input  logic [XLEN-1:0]           rf_rdata,
    output logic [XLEN-1:0]           data,
    output logic [SELW-1:0]           sel,
    output logic                      hazard
);

    logic found;

    // Only the youngest match is consulted; an older forwardable copy never masks a load-use.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        data   = rf_rdata;
        hazard = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found && used && vld[k] && (rd[k*REG_BITS +: REG_BITS] == rs)) begin
                found  = 1'b1;
                sel    = SELW'(k + 1);
                data   = stage_data[k*XLEN +: XLEN];
                hazard = is_load[k] && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard controller: in-flight rd shadow register, bypass muxes, stall counter.
module fwd_hazard_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN     = cpu_pkg::XLEN,
    parameter int unsigned REG_BITS = cpu_pkg::REG_BITS,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave bus
);

    localparam int unsigned SELW = sel_w(DEPTH);

    typedef struct packed {
        logic                vld;
        logic [REG_BITS-1:0] rd;
        logic                is_load;
    } ent_t;

    ent_t                      ent_q [DEPTH];
    ent_t                      ent_in;
    logic [DEPTH-1:0]          vld_v;
    logic [DEPTH*REG_BITS-1:0] rd_v;
    logic [DEPTH-1:0]          ld_v;
    logic                      hazard1;
    logic                      hazard2;
    logic                      stall;
    logic                      bubble;
    logic [31:0]               stall_cnt_q;

    always_comb begin
        vld_v = '0;
        rd_v  = '0;
        ld_v  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            vld_v[k]                       = ent_q[k].vld;
            rd_v[k*REG_BITS +: REG_BITS]   = ent_q[k].rd;
            ld_v[k]                        = ent_q[k].is_load;
        end
    end

    fwd_src_sel #(
        .XLEN(XLEN), .REG_BITS(REG_BITS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)
    ) u_sel1 (
        .used(bus.id_rs1_used), .rs(bus.id_rs1), .vld(vld_v), .rd(rd_v), .is_load(ld_v),
        .stage_data(bus.stage_data), .rf_rdata(bus.rf_rdata1),
        .data(bus.fwd_rs1_data), .sel(bus.fwd_sel1), .hazard(hazard1)
    );

    fwd_src_sel #(
        .XLEN(XLEN), .REG_BITS(REG_BITS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)
    ) u_sel2 (
        .used(bus.id_rs2_used), .rs(bus.id_rs2), .vld(vld_v), .rd(rd_v), .is_load(ld_v),
        .stage_data(bus.stage_data), .rf_rdata(bus.rf_rdata2),
        .data(bus.fwd_rs2_data), .sel(bus.fwd_sel2), .hazard(hazard2)
    );

    // x0 is never tracked, so a zero rd can never produce a match downstream.
    always_comb begin
        stall          = bus.id_valid && !bus.flush && (hazard1 || hazard2);
        bubble         = bus.flush || stall || !bus.id_valid;
        ent_in.vld     = bus.id_rf_wen && (bus.id_rd != '0);
        ent_in.rd      = bus.id_rd;
        ent_in.is_load = bus.id_is_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                ent_q[k] <= ent_q[k-1];
            end
            ent_q[0] <= bubble ? ent_t'('0) : ent_in;
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.occ       = vld_v;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed table, reset corners, randomized model compare.
module tb_fwd_hazard_unit;

    localparam int unsigned DEPTH    = 3;
    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned XLEN     = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fwd_hazard_unit_if #(.XLEN(XLEN), .REG_BITS(5), .DEPTH(DEPTH)) bus ();

    fwd_hazard_unit #(.XLEN(XLEN), .REG_BITS(5), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Reference: list of accepted instructions, index 0 = most recently issued.
    typedef struct {
        logic       vld;
        logic [4:0] rd;
        logic       ld;
    } m_ent_t;

    m_ent_t      q[$];
    int unsigned m_cnt;
    logic        m_stall;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       wen, ld, fl;
        int         sel1, sel2;
        logic       stall;
        logic [2:0] occ;
        int         cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ent_t z;
        z.vld = 1'b0; z.rd = '0; z.ld = 1'b0;
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(z);
        m_cnt = 0;
    endtask

    task automatic model_lookup(input logic used, input logic [4:0] rs,
                                output int sel, output logic hz);
        sel = 0;
        hz  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (used && q[k].vld && q[k].rd == rs) begin
                sel = k + 1;
                hz  = q[k].ld && (k < LOAD_LAT);
                return;
            end
        end
    endtask

    function automatic logic [31:0] exp_data(input int sel, input logic [31:0] rf);
        logic [DEPTH*XLEN-1:0] sd;
        sd = bus.stage_data;
        if (sel == 0) return rf;
        return sd[(sel-1)*XLEN +: XLEN];
    endfunction

    task automatic check_model();
        int   s1, s2;
        logic h1, h2;
        logic [2:0] occ;
        model_lookup(bus.id_rs1_used, bus.id_rs1, s1, h1);
        model_lookup(bus.id_rs2_used, bus.id_rs2, s2, h2);
        m_stall = bus.id_valid && !bus.flush && (h1 || h2);
        for (int k = 0; k < DEPTH; k++) occ[k] = q[k].vld;
        chk("m_sel1",  32'(bus.fwd_sel1), 32'(s1));
        chk("m_sel2",  32'(bus.fwd_sel2), 32'(s2));
        chk("m_data1", bus.fwd_rs1_data, exp_data(s1, bus.rf_rdata1));
        chk("m_data2", bus.fwd_rs2_data, exp_data(s2, bus.rf_rdata2));
        chk("m_stall", 32'(bus.stall), 32'(m_stall));
        chk("m_occ",   32'(bus.occ), 32'(occ));
        chk("m_cnt",   bus.stall_cnt, m_cnt);
    endtask

    task automatic advance();
        m_ent_t e;
        @(posedge clk);
        if (bus.flush || m_stall || !bus.id_valid) begin
            e.vld = 1'b0; e.rd = '0; e.ld = 1'b0;
        end else begin
            e.vld = bus.id_rf_wen && (bus.id_rd != 5'd0);
            e.rd  = bus.id_rd;
            e.ld  = bus.id_is_load;
        end
        q.push_front(e);
        void'(q.pop_back());
        if (m_stall) m_cnt++;
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        bus.id_valid    = v.v;
        bus.id_rs1      = v.rs1;
        bus.id_rs2      = v.rs2;
        bus.id_rs1_used = v.u1;
        bus.id_rs2_used = v.u2;
        bus.id_rd       = v.rd;
        bus.id_rf_wen   = v.wen;
        bus.id_is_load  = v.ld;
        bus.flush       = v.fl;
    endtask

    task automatic rand_inputs();
        bus.id_valid    = ($urandom_range(0, 9) != 0);
        bus.id_rs1      = 5'($urandom_range(0, 7));
        bus.id_rs2      = 5'($urandom_range(0, 7));
        bus.id_rs1_used = ($urandom_range(0, 4) != 0);
        bus.id_rs2_used = ($urandom_range(0, 4) != 0);
        bus.id_rd       = 5'($urandom_range(0, 7));
        bus.id_rf_wen   = ($urandom_range(0, 4) != 0);
        bus.id_is_load  = ($urandom_range(0, 2) == 0);
        bus.flush       = ($urandom_range(0, 9) == 0);
        bus.rf_rdata1   = $urandom;
        bus.rf_rdata2   = $urandom;
        bus.stage_data  = {$urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [31:0] sd0, sd1, sd2;
        int          s;
        vec_t        lw;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        model_clear();
        m_stall = 1'b0;

        // Reset held with arbitrary ID traffic: everything must read idle.
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            #3;
            chk("rst_stall", 32'(bus.stall), 32'd0);
            chk("rst_occ",   32'(bus.occ), 32'd0);
            chk("rst_cnt",   bus.stall_cnt, 32'd0);
            chk("rst_sel1",  32'(bus.fwd_sel1), 32'd0);
            chk("rst_sel2",  32'(bus.fwd_sel2), 32'd0);
        end
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        advance();

        // Directed sequence: ALU chain, youngest-wins, x0, load-use, flush over hazard, drop-out.
        sd0 = 32'hAAAA_0000; sd1 = 32'hBBBB_1111; sd2 = 32'hCCCC_2222;
        bus.stage_data = {sd2, sd1, sd0};
        bus.rf_rdata1  = 32'h1111_1111;
        bus.rf_rdata2  = 32'h2222_2222;
        //          v  rs1 rs2 u1 u2 rd wen ld fl  s1 s2 st occ     cnt
        tbl[0]  = '{1, 1,  2,  1, 1, 5, 1,  0, 0,  0, 0, 0, 3'b000, 0};
        tbl[1]  = '{1, 5,  0,  1, 1, 7, 1,  0, 0,  1, 0, 0, 3'b001, 0};
        tbl[2]  = '{1, 5,  7,  1, 1, 7, 1,  0, 0,  2, 1, 0, 3'b011, 0};
        tbl[3]  = '{1, 5,  7,  1, 1, 0, 1,  0, 0,  3, 1, 0, 3'b111, 0};
        tbl[4]  = '{1, 0,  7,  1, 0, 3, 1,  1, 0,  0, 0, 0, 3'b110, 0};
        tbl[5]  = '{1, 1,  3,  1, 1, 9, 1,  0, 0,  0, 1, 1, 3'b101, 0};
        tbl[6]  = '{1, 1,  3,  1, 1, 9, 1,  0, 0,  0, 2, 0, 3'b010, 1};
        tbl[7]  = '{1, 9,  0,  1, 0, 4, 1,  1, 0,  1, 0, 0, 3'b101, 1};
        tbl[8]  = '{1, 4,  4,  1, 1, 6, 1,  0, 1,  1, 1, 0, 3'b011, 1};
        tbl[9]  = '{0, 4,  0,  1, 0, 0, 0,  0, 0,  2, 0, 0, 3'b110, 1};
        tbl[10] = '{1, 4,  9,  1, 1, 0, 0,  0, 0,  3, 0, 0, 3'b100, 1};
        tbl[11] = '{1, 4,  0,  1, 0, 0, 0,  0, 0,  0, 0, 0, 3'b000, 1};
        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i]);
            #1;
            chk($sformatf("t%0d_sel1", i),  32'(bus.fwd_sel1), 32'(tbl[i].sel1));
            chk($sformatf("t%0d_sel2", i),  32'(bus.fwd_sel2), 32'(tbl[i].sel2));
            chk($sformatf("t%0d_stall", i), 32'(bus.stall), 32'(tbl[i].stall));
            chk($sformatf("t%0d_occ", i),   32'(bus.occ), 32'(tbl[i].occ));
            chk($sformatf("t%0d_cnt", i),   bus.stall_cnt, 32'(tbl[i].cnt));
            s = tbl[i].sel1;
            chk($sformatf("t%0d_data1", i), bus.fwd_rs1_data,
                (s == 0) ? 32'h1111_1111 : (s == 1) ? sd0 : (s == 2) ? sd1 : sd2);
            s = tbl[i].sel2;
            chk($sformatf("t%0d_data2", i), bus.fwd_rs2_data,
                (s == 0) ? 32'h2222_2222 : (s == 1) ? sd0 : (s == 2) ? sd1 : sd2);
            check_model();
            advance();
        end

        // Reset asserted while a load-use stall is active.
        lw = '{1, 1, 2, 0, 0, 3, 1, 1, 0, 0, 0, 0, 3'b000, 0};
        apply_vec(lw);
        #1;
        check_model();
        advance();
        lw = '{1, 1, 3, 0, 1, 8, 1, 0, 0, 0, 0, 0, 3'b000, 0};
        apply_vec(lw);
        #1;
        chk("ms_stall_before", 32'(bus.stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("ms_stall_after", 32'(bus.stall), 32'd0);
        chk("ms_occ",         32'(bus.occ), 32'd0);
        chk("ms_cnt",         bus.stall_cnt, 32'd0);
        chk("ms_sel2",        32'(bus.fwd_sel2), 32'd0);
        model_clear();
        m_stall      = 1'b0;
        bus.id_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        advance();

        // Randomized traffic against the reference list.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            #1;
            check_model();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
